// File: rtl/act_mem_rd_sequencer.sv
`default_nettype none
// ============================================================================
// act_mem_rd_sequencer - strided activation-row reader, streams rows over valid/ready
// Rev 1.0 | optional ACT_RD_SEQ_PERF_EN adds stall_wr_cnt / stall_bp_cnt
// ============================================================================
module act_mem_rd_sequencer #(
  parameter int N_LANES    = 4,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [LEN_W-1:0]            num_rows,
  input  logic [ADDR_W-1:0]           stride,
  input  logic                        wr_busy,
  output logic                        rd_enable,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [N_LANES*DATA_W-1:0]   rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LANES*DATA_W-1:0]   out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
`ifdef ACT_RD_SEQ_PERF_EN
  ,
  output logic [15:0]                 stall_wr_cnt,
  output logic [15:0]                 stall_bp_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ROW_W = N_LANES * DATA_W;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(N_LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  next_addr, last_addr, stride_q;
  logic [LEN_W-1:0]   rows_left;
  logic               inflight, inflight_last;
  logic [ROW_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               credit_ok, push, pop, accept, last_issue;

  // Credit covers the row still in flight so a capture never finds the FIFO full.
  assign credit_ok  = (fifo_count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
  assign accept     = (state == IDLE) && start;
  assign last_issue = (rows_left == LEN_W'(1));
  assign push       = inflight;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last   = out_valid & fifo_last[rd_ptr];
  assign rd_addr    = rd_enable ? next_addr : last_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_enable = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = (num_rows == '0) ? FIN : ISSUE;
      ISSUE: begin
        rd_enable = !wr_busy && credit_ok;
        if (rd_enable && last_issue) state_nxt = DRAIN;
      end
      DRAIN: if ((pop && out_last) || (fifo_count == '0 && !inflight)) state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_addr     <= '0;
      last_addr     <= '0;
      stride_q      <= '0;
      rows_left     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      inflight      <= rd_enable;
      inflight_last <= rd_enable && last_issue;
      if (accept) begin
        next_addr <= base_addr & ALIGN_MASK;
        stride_q  <= stride & ALIGN_MASK;
        rows_left <= num_rows;
      end else if (rd_enable) begin
        last_addr <= next_addr;
        next_addr <= next_addr + stride_q;
        rows_left <= rows_left - LEN_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

`ifdef ACT_RD_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_wr_cnt <= '0;
      stall_bp_cnt <= '0;
    end else if (accept) begin
      stall_wr_cnt <= '0;
      stall_bp_cnt <= '0;
    end else if (state == ISSUE) begin
      if (wr_busy && stall_wr_cnt != 16'hFFFF)
        stall_wr_cnt <= stall_wr_cnt + 16'd1;
      else if (!wr_busy && !credit_ok && stall_bp_cnt != 16'hFFFF)
        stall_bp_cnt <= stall_bp_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_mem_rd_sequencer.sv
`default_nettype none
// tb_act_mem_rd_sequencer: directed + randomized check against a queue-based row/address model.
module tb_act_mem_rd_sequencer;
  localparam int N_LANES = 4, DATA_W = 8, ADDR_W = 10, LEN_W = 10, FIFO_DEPTH = 4;
  localparam int ROW_W = N_LANES * DATA_W;
  localparam int N_MEM = 1 << (ADDR_W - 2);

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, wr_busy = 1'b0, out_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0, stride = '0;
  logic [LEN_W-1:0]  num_rows = '0;
  logic rd_enable, out_valid, out_last, busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [ROW_W-1:0]  rd_data = '0;
  logic [ROW_W-1:0]  out_data;
`ifdef ACT_RD_SEQ_PERF_EN
  logic [15:0] stall_wr_cnt, stall_bp_cnt;
`endif

  act_mem_rd_sequencer #(.N_LANES(N_LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                         .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .stride(stride), .wr_busy(wr_busy), .rd_enable(rd_enable), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef ACT_RD_SEQ_PERF_EN
    , .stall_wr_cnt(stall_wr_cnt), .stall_bp_cnt(stall_bp_cnt)
`endif
  );

  logic [ROW_W-1:0] mem [N_MEM];
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_enable) rd_data <= mem[rd_addr[ADDR_W-1:2]];

  typedef struct packed { logic [ROW_W-1:0] data; logic last; } row_t;
  logic [ADDR_W-1:0] addr_q[$];
  row_t              row_q[$];
  logic [ADDR_W-1:0] iss_log[$];
  logic [ADDR_W-1:0] last_addr_m;
  int  avail, issued_prev, n_tests, n_fail, cyc, start_cyc;
  int  cmd_issues, first_iss, last_iss, done_cnt;
  bit  active, done_due;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    addr_q.delete(); row_q.delete();
    avail = 0; issued_prev = 0; active = 0; done_due = 0; last_addr_m = '0;
  endtask

  // Per-cycle model: rows become visible two cycles after issue; credit = held rows + row in flight.
  task automatic monitor();
    bit exp_valid, exp_en, a_before, nxt_done;
    row_t r;
    logic [ADDR_W-1:0] a, st;
    exp_valid = avail > 0;
    exp_en = active && addr_q.size() > 0 && !wr_busy && (avail + issued_prev) < FIFO_DEPTH;
    chk("busy", busy, active);
    chk("done", done, done_due);
    chk("out_valid", out_valid, exp_valid);
    chk("rd_enable", rd_enable, exp_en);
    if (exp_en) begin
      chk("rd_addr", rd_addr, addr_q[0]);
      last_addr_m = addr_q.pop_front();
      iss_log.push_back(last_addr_m);
      cmd_issues++;
      if (first_iss < 0) first_iss = cyc;
      last_iss = cyc;
    end else begin
      chk("rd_addr_hold", rd_addr, last_addr_m);
    end
    nxt_done = 0;
    if (exp_valid) begin
      chk("out_data", out_data, row_q[0].data);
      chk("out_last", out_last, row_q[0].last);
      if (out_ready) begin
        r = row_q.pop_front();
        avail--;
        if (r.last) nxt_done = 1;
      end
    end
    avail += issued_prev;
    issued_prev = exp_en ? 1 : 0;
    if (done) done_cnt++;
    a_before = active;
    if (done_due) active = 0;
    if (start && !a_before) begin
      a  = base_addr & ~ADDR_W'(3);
      st = stride & ~ADDR_W'(3);
      cmd_issues = 0; first_iss = -1; iss_log.delete(); start_cyc = cyc;
      for (int k = 0; k < int'(num_rows); k++) begin
        addr_q.push_back(a);
        r.data = mem[a[ADDR_W-1:2]];
        r.last = (k == int'(num_rows) - 1);
        row_q.push_back(r);
        a = a + st;
      end
      active = 1;
      if (num_rows == '0) nxt_done = 1;
    end
    done_due = nxt_done;
    cyc++;
  endtask

  task automatic step();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic send(input logic [ADDR_W-1:0] b, input int n, input logic [ADDR_W-1:0] s);
    base_addr = b; num_rows = LEN_W'(n); stride = s; done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_idle(input bit rnd);
    for (int i = 0; i < 400 && active; i++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        wr_busy   = ($urandom_range(0, 3) == 0);
        if (active && $urandom_range(0, 7) == 0) begin
          base_addr = ADDR_W'($urandom); num_rows = LEN_W'($urandom_range(0, 10));
          stride = ADDR_W'($urandom); start = 1'b1;
        end
      end
      step();
      start = 1'b0;
    end
    chk("idle_timeout", active, 0);
    chk("queues_empty", addr_q.size() + row_q.size(), 0);
    wr_busy = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N_MEM; i++) mem[i] = $urandom;
    n_tests = 0; n_fail = 0; cyc = 0; done_cnt = 0; cmd_issues = 0; first_iss = -1; last_iss = 0;
    model_reset();
    @(negedge clk);
    step();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rd_addr", rd_addr, 0);
    reset = 1'b1;
    step();

    // Full-throughput read of four rows
    out_ready = 1'b1;
    send(10'h010, 4, 10'd4);
    run_idle(0);
    chk("A_issues", cmd_issues, 4);
    chk("A_first_issue", first_iss, start_cyc + 1);
    chk("A_back_to_back", last_iss - first_iss, 3);
    chk("A_done_cnt", done_cnt, 1);

    // Consumer stalled: only FIFO_DEPTH reads may go out
    out_ready = 1'b0;
    send(10'h010, 4, 10'd4);
    repeat (9) step();
    chk("B_issues_stalled", cmd_issues, FIFO_DEPTH);
    out_ready = 1'b1;
    run_idle(0);
    chk("B_done_cnt", done_cnt, 1);

    // Write collision on command cycles 2-4
    send(10'h010, 4, 10'd4);
    step();
    wr_busy = 1'b1;
    repeat (3) step();
    wr_busy = 1'b0;
    run_idle(0);
    chk("C_addr0", iss_log[0], 10'h010);
    chk("C_addr3", iss_log[3], 10'h01C);
`ifdef ACT_RD_SEQ_PERF_EN
    chk("C_stall_wr_cnt", stall_wr_cnt, 3);
    chk("C_stall_bp_cnt", stall_bp_cnt, 0);
`endif

    // Address wrap
    send(10'h3F8, 3, 10'd4);
    run_idle(0);
    chk("D_wrap0", iss_log[0], 10'h3F8);
    chk("D_wrap1", iss_log[1], 10'h3FC);
    chk("D_wrap2", iss_log[2], 10'h000);

    // Zero rows, with a second start landing while busy
    send(10'h055, 0, 10'd4);
    base_addr = 10'h100; num_rows = 10'd5; start = 1'b1;
    step();
    start = 1'b0;
    run_idle(0);
    chk("E_issues", cmd_issues, 0);
    chk("E_done_cnt", done_cnt, 1);

    // Start during ISSUE is ignored
    send(10'h020, 6, 10'd8);
    base_addr = 10'h200; num_rows = 10'd2; start = 1'b1;
    step();
    start = 1'b0;
    run_idle(0);
    chk("F_issues", cmd_issues, 6);

    // Async reset while draining with two rows held
    out_ready = 1'b0;
    send(10'h040, 2, 10'd4);
    repeat (3) step();
    chk("G_valid_before_reset", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("G_valid_in_reset", out_valid, 0);
    chk("G_busy_in_reset", busy, 0);
    model_reset();
    @(negedge clk);
    step();
    reset = 1'b1; out_ready = 1'b1;
    step();
    send(10'h080, 5, 10'd12);
    run_idle(0);
    chk("G_after_issues", cmd_issues, 5);
    chk("G_after_done", done_cnt, 1);

    // Randomized commands with random backpressure and write collisions
    for (int t = 0; t < 25; t++) begin
      send(ADDR_W'($urandom), $urandom_range(0, 10), ADDR_W'($urandom));
      run_idle(1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
